// File: rtl/mem_port_ctrl_if.sv
// mem_port_ctrl_if: bundles the fetch port, the load/store port and RAM port A of
// mem_port_ctrl.
//   slave  modport: the controller side. It receives the requests and ram_q, and
//                   drives the acks, the read data, the RAM address/data/we and busy.
//   master modport: the requesters plus the RAM, i.e. the opposite directions.
interface mem_port_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  // Instruction-fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_data;
  // Load/store port
  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_ack;
  logic [DATA_W-1:0] ls_rdata;
  // RAM port A
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_we;
  logic [DATA_W-1:0] ram_q;
  // Status
  logic              busy;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ram_q,
    output if_ack, if_data, ls_ack, ls_rdata, ram_addr, ram_data, ram_we, busy
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ram_q,
    input  if_ack, if_data, ls_ack, ls_rdata, ram_addr, ram_data, ram_we, busy
  );
endinterface

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: shares a single-port RAM between an instruction-fetch port and a
// load/store port. A four-state FSM (idle, write, read, resp) runs each
// transaction. Every RAM output and every ack is a register.
//   i_clk   : clock; all state changes on the rising edge
//   i_rst_n : asynchronous, active-low reset
//   io_bus  : mem_port_ctrl_if.slave, carrying the request/ack ports and RAM port A
// Parameters: ADDR_W (word address width), DATA_W (word width) and RD_LAT (RAM read
// latency in clocks, 1..3).
module mem_port_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  mem_port_ctrl_if.slave  io_bus
);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StResp} state_e;

  // The last read edge is the one at which the counter has already seen RD_LAT edges.
  localparam logic [1:0] LatLast = 2'(RD_LAT);

  state_e            r_state;
  logic [1:0]        r_lat_cnt;
  logic              r_ls_last;  // the previous grant went to load/store
  logic              r_gnt_ls;   // the read in flight belongs to load/store
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_data;
  logic              r_ram_we;
  logic              r_if_ack;
  logic              r_ls_ack;
  logic [DATA_W-1:0] r_if_data;
  logic [DATA_W-1:0] r_ls_rdata;

  logic w_ls_win;
  logic w_if_win;

  // Load/store has priority, except that a pending fetch goes first right after a
  // load/store grant. Under contention the two ports therefore alternate.
  assign w_ls_win = io_bus.ls_req && !(r_ls_last && io_bus.if_req);
  assign w_if_win = io_bus.if_req && !w_ls_win;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_lat_cnt  <= 2'd0;
      r_ls_last  <= 1'b0;
      r_gnt_ls   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_data <= '0;
      r_ram_we   <= 1'b0;
      r_if_ack   <= 1'b0;
      r_ls_ack   <= 1'b0;
      r_if_data  <= '0;
      r_ls_rdata <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          // This is the grant edge. Request fields are captured here only, so later
          // changes on the inputs cannot reach the RAM.
          if (w_ls_win) begin
            r_ram_addr <= io_bus.ls_addr;
            r_gnt_ls   <= 1'b1;
            r_ls_last  <= 1'b1;
            r_lat_cnt  <= 2'd0;
            if (io_bus.ls_we) begin
              r_ram_data <= io_bus.ls_wdata;
              r_ram_we   <= 1'b1;
              r_state    <= StWrite;
            end else begin
              r_ram_we <= 1'b0;
              r_state  <= StRead;
            end
          end else if (w_if_win) begin
            r_ram_addr <= io_bus.if_addr;
            r_gnt_ls   <= 1'b0;
            r_ls_last  <= 1'b0;
            r_lat_cnt  <= 2'd0;
            r_ram_we   <= 1'b0;
            r_state    <= StRead;
          end else begin
            r_ram_we <= 1'b0;
          end
        end
        StWrite: begin
          r_ram_we <= 1'b0;
          r_ls_ack <= 1'b1;
          r_state  <= StResp;
        end
        StRead: begin
          if (r_lat_cnt == LatLast) begin
            r_lat_cnt <= 2'd0;
            if (r_gnt_ls) begin
              r_ls_rdata <= io_bus.ram_q;
              r_ls_ack   <= 1'b1;
            end else begin
              r_if_data <= io_bus.ram_q;
              r_if_ack  <= 1'b1;
            end
            r_state <= StResp;
          end else begin
            r_lat_cnt <= r_lat_cnt + 2'd1;
          end
        end
        StResp: begin
          r_if_ack <= 1'b0;
          r_ls_ack <= 1'b0;
          r_state  <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_bus.ram_addr = r_ram_addr;
  assign io_bus.ram_data = r_ram_data;
  assign io_bus.ram_we   = r_ram_we;
  assign io_bus.if_ack   = r_if_ack;
  assign io_bus.if_data  = r_if_data;
  assign io_bus.ls_ack   = r_ls_ack;
  assign io_bus.ls_rdata = r_ls_rdata;
  assign io_bus.busy     = (r_state != StIdle);

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Testbench for mem_port_ctrl. It runs a table of directed transactions, hand-written
// corner-case sequences and randomised rounds. A transaction-level model of the memory
// and the arbitration supplies every expected value.
module tb_mem_port_ctrl;

  localparam int RD_LAT = 1;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   n_overlap;

  mem_port_ctrl_if #(.ADDR_W(12), .DATA_W(16)) bus ();

  mem_port_ctrl #(.ADDR_W(12), .DATA_W(16), .RD_LAT(RD_LAT)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model with a synchronous read pipeline RD_LAT deep.
  logic [15:0] ram [4096];
  logic [15:0] q_pipe [3];
  assign bus.ram_q = q_pipe[RD_LAT-1];

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = {4'hC, 12'(i)};
    ram[3] = 16'h1234;
    for (int i = 0; i < 3; i++) q_pipe[i] = 16'h0;
    forever begin
      @(posedge clk);
      q_pipe[0] <= ram[bus.ram_addr];
      q_pipe[1] <= q_pipe[0];
      q_pipe[2] <= q_pipe[1];
      if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_data;
    end
  end

  // Transaction-level reference state.
  logic [15:0] m_mem [4096];
  bit          m_ls_last;
  logic [11:0] m_last_addr;
  logic [15:0] m_last_wdata, m_last_if, m_last_ls;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (bus.if_ack && bus.ls_ack) n_overlap++;
  endtask

  task automatic model_reset();
    m_ls_last    = 1'b0;
    m_last_addr  = '0;
    m_last_wdata = '0;
    m_last_if    = '0;
    m_last_ls    = '0;
  endtask

  // Predicts the grant order and the returned data for one round, then commits it.
  task automatic predict(input bit do_if, input bit do_ls, input bit we,
                         input logic [11:0] ifa, input logic [11:0] lsa,
                         input logic [15:0] wd, output bit ls_first,
                         output logic [15:0] e_if, output logic [15:0] e_ls);
    bit serve_ls;
    ls_first = do_ls && !(m_ls_last && do_if);
    e_if = m_last_if;
    e_ls = m_last_ls;
    for (int k = 0; k < 2; k++) begin
      serve_ls = (k == 0) ? ls_first : !ls_first;
      if (serve_ls && do_ls) begin
        m_last_addr = lsa;
        if (we) begin
          m_mem[lsa]   = wd;
          m_last_wdata = wd;
        end else begin
          e_ls      = m_mem[lsa];
          m_last_ls = e_ls;
        end
        m_ls_last = 1'b1;
      end else if (!serve_ls && do_if) begin
        m_last_addr = ifa;
        e_if        = m_mem[ifa];
        m_last_if   = e_if;
        m_ls_last   = 1'b0;
      end
    end
  endtask

  // Raises the requests, then serves every one of them and checks the grant, the
  // latency, the ack and the data. corrupt changes the request fields right after
  // the grant edge (single-requester rounds only).
  task automatic serve(input bit do_if, input bit do_ls, input bit we,
                       input logic [11:0] ifa, input logic [11:0] lsa,
                       input logic [15:0] wd, input bit ls_first,
                       input logic [15:0] e_if, input logic [15:0] e_ls,
                       input bit corrupt);
    bit pend_if, pend_ls, cur_ls;
    int n, exp_lat, we_seen;
    bus.if_req   = do_if;
    bus.if_addr  = ifa;
    bus.ls_req   = do_ls;
    bus.ls_we    = we;
    bus.ls_addr  = lsa;
    bus.ls_wdata = wd;
    pend_if = do_if;
    pend_ls = do_ls;
    while (pend_if || pend_ls) begin
      cur_ls  = (pend_if && pend_ls) ? ls_first : pend_ls;
      exp_lat = (cur_ls && we) ? 2 : RD_LAT + 2;
      n = 0;
      we_seen = 0;
      do begin
        step();
        n++;
        if (n == 1) begin
          check("grant_busy", 32'(bus.busy), 32'd1);
          check("grant_addr", 32'(bus.ram_addr), 32'(cur_ls ? lsa : ifa));
          check("grant_we", 32'(bus.ram_we), 32'(cur_ls && we));
          if (cur_ls && we) check("grant_wdata", 32'(bus.ram_data), 32'(wd));
          if (corrupt && !(do_if && do_ls)) begin
            bus.ls_wdata = 16'h0000;
            bus.ls_addr  = lsa ^ 12'h001;
            bus.if_addr  = ifa ^ 12'h001;
            bus.ls_we    = !we;
          end
        end else if (bus.ram_we) begin
          we_seen++;
        end
      end while (!bus.if_ack && !bus.ls_ack && n < 20);
      check("ack_latency", 32'(n), 32'(exp_lat));
      check("ack_who", {30'd0, bus.ls_ack, bus.if_ack}, cur_ls ? 32'd2 : 32'd1);
      check("we_after_grant", 32'(we_seen), 32'd0);
      if (cur_ls && !we) check("ls_rdata", 32'(bus.ls_rdata), 32'(e_ls));
      if (!cur_ls) check("if_data", 32'(bus.if_data), 32'(e_if));
      if (cur_ls) begin
        bus.ls_req = 1'b0;
        pend_ls    = 1'b0;
      end else begin
        bus.if_req = 1'b0;
        pend_if    = 1'b0;
      end
      step();
      check("ack_one_cycle", {30'd0, bus.ls_ack, bus.if_ack}, 32'd0);
      check("resp_to_idle", 32'(bus.busy), 32'd0);
    end
  endtask

  task automatic do_reset();
    bus.if_req   = 1'b0;
    bus.ls_req   = 1'b0;
    bus.ls_we    = 1'b0;
    bus.if_addr  = '0;
    bus.ls_addr  = '0;
    bus.ls_wdata = '0;
    rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_outputs", {bus.ram_we, bus.if_ack, bus.ls_ack, bus.ram_addr, bus.ram_data},
          32'd0);
    check("rst_rdata", {bus.if_data, bus.ls_rdata}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit          do_if;
    bit          do_ls;
    bit          we;
    logic [11:0] ifa;
    logic [11:0] lsa;
    logic [15:0] wd;
    bit          ls_first;
    logic [15:0] e_if;
    logic [15:0] e_ls;
  } vec_t;

  vec_t tbl [10];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    bit          lf, dif, dls, dwe, cor;
    logic [15:0] eif, els, wdr, save_if, save_ls;
    logic [11:0] ifr, lsr;
    int          bad;

    n_checks  = 0;
    n_errors  = 0;
    n_overlap = 0;
    for (int i = 0; i < 4096; i++) m_mem[i] = {4'hC, 12'(i)};
    m_mem[3] = 16'h1234;

    //           if  ls  we  if_addr  ls_addr  wdata     lsfirst e_if      e_ls
    tbl[0] = '{1'b0, 1'b1, 1'b1, 12'h000, 12'h010, 16'hBEEF, 1'b1, 16'h0000, 16'h0000};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 12'h000, 12'h010, 16'h0000, 1'b1, 16'h0000, 16'hBEEF};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 12'h003, 12'h000, 16'h0000, 1'b0, 16'h1234, 16'hBEEF};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 12'h010, 12'h003, 16'h0000, 1'b1, 16'hBEEF, 16'h1234};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 12'h000, 12'hFFF, 16'h5A5A, 1'b1, 16'hBEEF, 16'h1234};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 12'hFFF, 12'h003, 16'h0000, 1'b0, 16'h5A5A, 16'h1234};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 12'h000, 12'h000, 16'h7777, 1'b0, 16'hC000, 16'h1234};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 12'h000, 12'h000, 16'h0000, 1'b1, 16'hC000, 16'h7777};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 12'h001, 12'h000, 16'h0000, 1'b0, 16'hC001, 16'h7777};
    tbl[9] = '{1'b1, 1'b1, 1'b1, 12'h005, 12'h005, 16'h0F0F, 1'b1, 16'h0F0F, 16'h7777};

    rst_n = 1'b1;
    #2;
    do_reset();

    // Directed table
    for (int i = 0; i < 10; i++) begin
      predict(tbl[i].do_if, tbl[i].do_ls, tbl[i].we, tbl[i].ifa, tbl[i].lsa, tbl[i].wd,
              lf, eif, els);
      serve(tbl[i].do_if, tbl[i].do_ls, tbl[i].we, tbl[i].ifa, tbl[i].lsa, tbl[i].wd,
            tbl[i].ls_first, tbl[i].e_if, tbl[i].e_ls, 1'b0);
    end

    // Idle for 10 cycles: quiet, everything holds
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.busy || bus.ram_we || bus.if_ack || bus.ls_ack) bad++;
    end
    check("idle_quiet", 32'(bad), 32'd0);
    check("idle_ram_addr", 32'(bus.ram_addr), 32'(m_last_addr));
    check("idle_ram_data", 32'(bus.ram_data), 32'(m_last_wdata));
    check("idle_if_data", 32'(bus.if_data), 32'(m_last_if));
    check("idle_ls_rdata", 32'(bus.ls_rdata), 32'(m_last_ls));

    // Stale data: request fields change right after the grant edge
    predict(1'b0, 1'b1, 1'b1, 12'h000, 12'h020, 16'hA5A5, lf, eif, els);
    serve(1'b0, 1'b1, 1'b1, 12'h000, 12'h020, 16'hA5A5, lf, eif, els, 1'b1);
    check("stale_ram", 32'(ram[12'h020]), 32'h0000A5A5);
    predict(1'b0, 1'b1, 1'b0, 12'h000, 12'h020, 16'h0000, lf, eif, els);
    serve(1'b0, 1'b1, 1'b0, 12'h000, 12'h020, 16'h0000, lf, eif, els, 1'b0);
    predict(1'b0, 1'b1, 1'b0, 12'h000, 12'h021, 16'h0000, lf, eif, els);
    serve(1'b0, 1'b1, 1'b0, 12'h000, 12'h021, 16'h0000, lf, eif, els, 1'b0);

    // Contention from reset: ls, if, ls, if
    do_reset();
    for (int r = 0; r < 2; r++) begin
      predict(1'b1, 1'b1, 1'b0, 12'h003, 12'h010, 16'h0000, lf, eif, els);
      serve(1'b1, 1'b1, 1'b0, 12'h003, 12'h010, 16'h0000, 1'b1, 16'h1234, 16'hBEEF, 1'b0);
    end

    // Reset while the write is in flight
    bus.ls_req   = 1'b1;
    bus.ls_we    = 1'b1;
    bus.ls_addr  = 12'h030;
    bus.ls_wdata = 16'h1111;
    step();
    check("mid_we_set", 32'(bus.ram_we), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_we_abort", 32'(bus.ram_we), 32'd0);
    check("mid_busy", 32'(bus.busy), 32'd0);
    check("mid_no_ack", 32'(bus.ls_ack), 32'd0);
    bus.ls_req = 1'b0;
    bad = 0;
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.ls_ack || bus.if_ack || bus.busy) bad++;
    end
    check("mid_quiet_after", 32'(bad), 32'd0);
    check("mid_mem_kept", 32'(ram[12'h030]), 32'h0000C030);
    predict(1'b0, 1'b1, 1'b0, 12'h000, 12'h030, 16'h0000, lf, eif, els);
    serve(1'b0, 1'b1, 1'b0, 12'h000, 12'h030, 16'h0000, lf, eif, els, 1'b0);

    // Randomised rounds against the model
    for (int r = 0; r < 40; r++) begin
      dls = 1'($urandom_range(0, 1));
      dif = dls ? 1'($urandom_range(0, 1)) : 1'b1;
      dwe = 1'($urandom_range(0, 1));
      ifr = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom_range(0, 15));
      lsr = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom_range(0, 15));
      wdr = 16'($urandom);
      cor = !(dif && dls) && ($urandom_range(0, 3) == 0);
      predict(dif, dls, dwe, ifr, lsr, wdr, lf, eif, els);
      serve(dif, dls, dwe, ifr, lsr, wdr, lf, eif, els, cor);
      if (dls && dwe) check("rand_ram_word", 32'(ram[lsr]), 32'(m_mem[lsr]));
    end

    save_if = m_last_if;
    save_ls = m_last_ls;
    check("final_if_data", 32'(bus.if_data), 32'(save_if));
    check("final_ls_rdata", 32'(bus.ls_rdata), 32'(save_ls));
    check("ack_overlap", 32'(n_overlap), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
